// File: rtl/chunked_subtractor_pkg.sv
// Shared types, default sizing and the one-bit full-subtractor equations
// used by the chunked subtractor and its W-bit ripple slice.
package chunked_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_N  = 32;
  localparam int DEF_W  = 8;
  localparam int CHUNKS = DEF_N / DEF_W;

  // A single-chunk configuration still needs a one-bit index register.
  function automatic int idx_width(input int chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction

  localparam int IDX_W = idx_width(CHUNKS);

  // Returns {bout, d} for x - y - bin.
  function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bin);
    logic d;
    logic bout;
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~x & bin) | (y & bin);
    return {bout, d};
  endfunction

endpackage

// File: rtl/chunked_subtractor_chunk_sub_w.sv
// Combinational W-bit ripple-borrow subtractor: d = a - b - bin, bout = final borrow.
module chunk_sub_w
  import chunked_subtractor_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] d,
  output logic         bout
);

  logic [W:0] w_borrow;

  assign w_borrow[0] = bin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign {w_borrow[i+1], d[i]} = full_sub(a[i], b[i], w_borrow[i]);
  end

  assign bout = w_borrow[W];

endmodule

// File: rtl/chunked_subtractor.sv
// Multi-cycle unsigned subtractor: one W-bit chunk per clock, LSB first,
// with valid/ready handshakes on the operand and result sides.
module chunked_subtractor
  import chunked_subtractor_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] minuend,
  input  logic [N-1:0] subtrahend,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] difference,
  output logic         borrow_out
);

  localparam int L_CHUNKS = N / W;
  localparam int L_IDX_W  = idx_width(L_CHUNKS);
  localparam logic [L_IDX_W-1:0] L_LAST = L_IDX_W'(L_CHUNKS - 1);

  if ((N % W) != 0) begin : g_bad_width
    $error("chunked_subtractor: N must be a multiple of W");
  end

  state_t               r_state;
  state_t               r_next;
  logic [N-1:0]         r_a;
  logic [N-1:0]         r_b;
  logic [N-1:0]         r_diff;
  logic                 r_borrow;
  logic                 r_borrow_out;
  logic [L_IDX_W-1:0]   r_k;
  logic [W-1:0]         w_a_chunk;
  logic [W-1:0]         w_b_chunk;
  logic [W-1:0]         w_d;
  logic                 w_bout;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; combinational blocks use blocking assignments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= r_next;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    r_next = r_state;
    unique case (r_state)
      IDLE:    if (in_valid)      r_next = BUSY;
      BUSY:    if (r_k == L_LAST) r_next = DONE;
      DONE:    if (out_ready)     r_next = IDLE;
      default:                    r_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  always_comb begin
    w_a_chunk = '0;
    w_b_chunk = '0;
    for (int i = 0; i < L_CHUNKS; i++) begin
      if (r_k == L_IDX_W'(i)) begin
        w_a_chunk = r_a[i*W +: W];
        w_b_chunk = r_b[i*W +: W];
      end
    end
  end

  chunk_sub_w #(.W(W)) u_chunk_sub (
    .a    (w_a_chunk),
    .b    (w_b_chunk),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bout)
  );

  // Result register keeps the last difference/borrow until the next operation overwrites it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a          <= '0;
      r_b          <= '0;
      r_diff       <= '0;
      r_borrow     <= 1'b0;
      r_borrow_out <= 1'b0;
      r_k          <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a      <= minuend;
            r_b      <= subtrahend;
            r_borrow <= 1'b0;
            r_k      <= '0;
          end
        end
        BUSY: begin
          for (int i = 0; i < L_CHUNKS; i++) begin
            if (r_k == L_IDX_W'(i)) r_diff[i*W +: W] <= w_d;
          end
          r_borrow <= w_bout;
          r_k      <= r_k + 1'b1;
          if (r_k == L_LAST) r_borrow_out <= w_bout;
        end
        default: ;
      endcase
    end
  end

  assign difference = r_diff;
  assign borrow_out = r_borrow_out;

endmodule

// File: tb/tb_chunked_subtractor.sv
// Directed and randomized checks of chunked_subtractor (N=32, W=8).
module tb_chunked_subtractor;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] minuend;
  logic [31:0] subtrahend;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] difference;
  logic        borrow_out;

  int n_pass;
  int n_total;
  int n_fail;

  // random-phase bookkeeping (producer and consumer use disjoint variables)
  logic [32:0] exp_q[$];
  logic [31:0] ra, rb;
  logic        p_fired;
  int          p_waited;
  int          c_got;
  int          c_cyc;
  logic [32:0] c_exp;
  logic        c_take;

  chunked_subtractor #(.N(32), .W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .minuend    (minuend),
    .subtrahend (subtrahend),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .difference (difference),
    .borrow_out (borrow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation with out_ready already high: checks latency, result and a one-cycle DONE.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_d, input logic exp_bo);
    int lat;
    out_ready  = 1'b1;
    minuend    = a;
    subtrahend = b;
    in_valid   = 1'b1;
    check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    tick();
    in_valid   = 1'b0;
    minuend    = ~a;
    subtrahend = ~b;
    // Counting the accept edge as clock 1, out_valid is high after clock 5.
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(5));
    check({tag, "_diff"}, 64'(difference), 64'(exp_d));
    check({tag, "_borrow"}, 64'(borrow_out), 64'(exp_bo));
    check({tag, "_busy_in_ready"}, 64'(in_ready), 64'(0));
    tick();
    check({tag, "_valid_drop"}, 64'(out_valid), 64'(0));
    check({tag, "_idle_in_ready"}, 64'(in_ready), 64'(1));
    check({tag, "_diff_held"}, 64'(difference), 64'(exp_d));
  endtask

  initial begin
    int   wait_cyc;
    logic seen_valid;
    n_pass = 0; n_total = 0; n_fail = 0;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    minuend = '0; subtrahend = '0;

    // Reset values
    #2 rst = 1'b1;
    #1;
    check("rst_in_ready",  64'(in_ready),   64'(1));
    check("rst_out_valid", 64'(out_valid),  64'(0));
    check("rst_diff",      64'(difference), 64'(0));
    check("rst_borrow",    64'(borrow_out), 64'(0));
    @(negedge clk) rst = 1'b0;
    tick();

    do_op("basic",      32'd5,          32'd3,          32'h0000_0002, 1'b0);
    do_op("underflow",  32'd0,          32'd1,          32'hFFFF_FFFF, 1'b1);
    do_op("cross",      32'h0000_0100,  32'h0000_0001,  32'h0000_00FF, 1'b0);
    do_op("chain",      32'h8000_0000,  32'h0000_0001,  32'h7FFF_FFFF, 1'b0);
    do_op("equal",      32'hDEAD_BEEF,  32'hDEAD_BEEF,  32'h0000_0000, 1'b0);
    do_op("neg",        32'd3,          32'd5,          32'hFFFF_FFFE, 1'b1);
    tick();

    // Backpressure: result held for 10 cycles, a stray in_valid pulse is ignored
    out_ready  = 1'b0;
    minuend    = 32'h1234_5678;
    subtrahend = 32'h0FED_CBA9;
    in_valid   = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_cyc = 0;
    while (!out_valid && wait_cyc < 20) begin
      tick();
      wait_cyc++;
    end
    check("bp_valid_rise", 64'(out_valid), 64'(1));
    for (int i = 0; i < 10; i++) begin
      check("bp_valid",    64'(out_valid),  64'(1));
      check("bp_diff",     64'(difference), 64'(32'h0246_8ACF));
      check("bp_borrow",   64'(borrow_out), 64'(0));
      check("bp_in_ready", 64'(in_ready),   64'(0));
      if (i == 3) begin
        minuend    = 32'hFFFF_FFFF;
        subtrahend = 32'h0000_0000;
        in_valid   = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_valid",    64'(out_valid),  64'(0));
    check("bp_release_in_ready", 64'(in_ready),   64'(1));
    check("bp_release_diff",     64'(difference), 64'(32'h0246_8ACF));
    tick();
    check("bp_pulse_ignored", 64'(in_ready), 64'(1));

    // Reset during the second BUSY cycle
    minuend    = 32'h1234_5678;
    subtrahend = 32'h0000_0001;
    in_valid   = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("mid_busy", 64'(in_ready), 64'(0));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_in_ready",  64'(in_ready),   64'(1));
    check("mid_rst_out_valid", 64'(out_valid),  64'(0));
    check("mid_rst_diff",      64'(difference), 64'(0));
    check("mid_rst_borrow",    64'(borrow_out), 64'(0));
    @(negedge clk) rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen_valid = 1'b1;
    end
    check("mid_rst_no_valid", 64'(seen_valid), 64'(0));
    do_op("after_rst", 32'd7, 32'd2, 32'd5, 1'b0);

    // Random back-to-back traffic against a scoreboard
    c_got = 0;
    fork
      begin
        for (int n = 0; n < 1000; n++) begin
          int gap;
          gap = $urandom_range(0, 2);
          in_valid = 1'b0;
          repeat (gap) tick();
          ra = $urandom;
          rb = $urandom;
          if (n % 50 == 0) rb = ra;
          if (n % 50 == 1) begin ra = 32'd0; rb = 32'd1; end
          minuend    = ra;
          subtrahend = rb;
          in_valid   = 1'b1;
          p_fired  = 1'b0;
          p_waited = 0;
          while (!p_fired && p_waited < 64) begin
            p_fired = in_ready;
            tick();
            p_waited++;
          end
          if (p_fired) exp_q.push_back({1'b0, ra} - {1'b0, rb});
          else begin
            check("rnd_accept", 64'(p_fired), 64'(1));
            break;
          end
        end
        in_valid = 1'b0;
      end
      begin
        c_cyc = 0;
        while (c_got < 1000 && c_cyc < 30000) begin
          out_ready = 1'($urandom_range(0, 1));
          c_take = out_valid && out_ready;
          if (c_take) begin
            if (exp_q.size() == 0) begin
              check("rnd_unexpected_result", 64'(exp_q.size()), 64'(1));
            end else begin
              c_exp = exp_q.pop_front();
              check("rnd_result", 64'({borrow_out, difference}), 64'(c_exp));
            end
            c_got++;
          end
          tick();
          c_cyc++;
        end
      end
    join
    check("rnd_count", 64'(c_got), 64'(1000));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
